mult_sched: RTL
===============

Name: mult_sched

Overview:
- Sequencer and arbiter for the shared shift-add multiplier datapath.
- Two requesters share one datapath under round-robin arbitration.
- For the granted requester it issues the load / add / shift / inbit / sel / valid control sequence for WIDTH iterations, then pulses that requester's done.
- Sits between the two client blocks and the multiplier datapath; replaces direct start-driven sequencing of the datapath.

Parameters:
- WIDTH, 8, operand width in bits; equals the number of EXEC iterations.
- CNT_W, 4, iteration counter width; must satisfy 2**CNT_W > WIDTH-1.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- req  input  2  per-requester multiply request, level-sensitive.
- sign  input  1  current multiplier LSB from the datapath.
- cout  input  1  adder carry-out from the datapath.
- gnt  output  2  one-hot grant; also drives the datapath operand-mux select.
- done  output  2  one-cycle completion pulse to the granted requester.
- busy  output  1  high whenever state is not IDLE.
- load  output  1  load operands into the datapath registers.
- sel  output  2  datapath mux select: IDLE 00, LOAD 10, EXEC 01, DONE 11.
- add  output  1  accumulate multiplicand into the partial product.
- shift  output  1  shift the product/multiplier register right by one.
- inbit  output  1  bit shifted into the product MSB.
- valid  output  1  product register holds a final result.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, counter=0, RR pointer last=1 so requester 0 has priority.
  - All outputs are 0, including sel=00.
  - Reset mid-operation aborts the multiply; no done pulse is issued.
- State machine: IDLE -> LOAD -> EXEC (WIDTH cycles) -> DONE -> IDLE.
- IDLE:
  - If req != 0, the grant winner is latched into gnt (registered) and the next state is LOAD.
  - Round-robin: with both requests high, grant goes to ~last. With one request high, it goes to that requester.
- LOAD (1 cycle): load=1, sel=10, counter <= WIDTH-1.
- EXEC:
  - sel=01, shift=1, add=sign (combinational), inbit = add & cout; when add=0, inbit=0.
  - Counter decrements each cycle; when counter==0 this is the last EXEC cycle, next state DONE.
- DONE (1 cycle):
  - valid=1, sel=11, done[g]=1 for the granted g.
  - last <= g; gnt is cleared on exit to IDLE.
- gnt stays stable and one-hot from LOAD through DONE. It is never 2'b11.
- Latency: request sampled at IDLE edge k gives LOAD in cycle k+1, EXEC in k+2..k+1+WIDTH, done in cycle k+2+WIDTH. For WIDTH=8, done arrives 10 cycles after sampling.
- Requests dropped mid-operation are ignored; the multiply completes and done is still pulsed.
- A requester must drop req in its done cycle. If req is still high in the following IDLE cycle, it is a new request and arbitrates normally (it loses to the other requester if both are pending).
- The arbiter returns to IDLE for exactly one cycle between operations; back-to-back throughput is one result per WIDTH+3 cycles.
- sign and cout are sampled only in EXEC. In other states add=0 and inbit=0 regardless of input values (including X).

Decomposition:
- Shared package holds:
  - state typedef/constants: IDLE=2'b00, LOAD=2'b01, EXEC=2'b10, DONE=2'b11;
  - sel encodings SEL_IDLE/SEL_LOAD/SEL_EXEC/SEL_DONE;
  - the requester count NREQ=2.
- One natural sub-module: rr_arb2, the two-way round-robin arbiter (req, last -> one-hot winner). Everything else stays in mult_sched.

Test Plan:
- Reset mid-EXEC: drop reset 4 cycles into EXEC -> all outputs 0 immediately, no done pulse. After release with req=01, a full 10-cycle sequence completes.
- Single requester, WIDTH=8, req=01, sign pattern 1,0,1,1,0,0,0,1 -> expected sequence:
  - LOAD: one cycle with load=1, sel=10;
  - EXEC: 8 cycles with shift=1, sel=01, add following the sign pattern;
  - DONE: done=01, valid=1, sel=11 in cycle 10;
  - gnt=01 throughout.
- Simultaneous req=11 after reset -> requester 0 is served first. Requester 1 is granted in the first LOAD after requester 0's DONE plus one IDLE cycle; done pulses appear in order 01 then 10.
- Both requesters held high for 4 operations -> grants alternate 01,10,01,10. Each done is 11 cycles apart and gnt is never 11.
- cout=1 with sign=0 in EXEC -> add=0, inbit=0. With sign=1 and cout=1 -> add=1, inbit=1. sign/cout set to X in IDLE -> add=0, inbit=0, no X on any output.

Source files
------------

// File: rtl/mult_sched_pkg.sv
// mult_sched_pkg: shared state, sel encodings and requester count for the multiplier scheduler
package mult_sched_pkg;
    localparam int NREQ = 2;
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        LOAD = 2'b01,
        EXEC = 2'b10,
        DONE = 2'b11
    } state_t;
    localparam logic [1:0] SEL_IDLE = 2'b00;
    localparam logic [1:0] SEL_LOAD = 2'b10;
    localparam logic [1:0] SEL_EXEC = 2'b01;
    localparam logic [1:0] SEL_DONE = 2'b11;
endpackage

// File: rtl/mult_sched_if.sv
// mult_sched_if: client handshake (req/gnt/done) plus datapath control/status bundle
// master: scheduler side (drives grants and controls); slave: clients and datapath
interface mult_sched_if;
    import mult_sched_pkg::*;
    logic [NREQ-1:0] req;
    logic [NREQ-1:0] gnt;
    logic [NREQ-1:0] done;
    logic            sign;
    logic            cout;
    logic            busy;
    logic            load;
    logic [1:0]      sel;
    logic            add;
    logic            shift;
    logic            inbit;
    logic            valid;
    modport master (
        input  req, sign, cout,
        output gnt, done, busy, load, sel, add, shift, inbit, valid
    );
    modport slave (
        output req, sign, cout,
        input  gnt, done, busy, load, sel, add, shift, inbit, valid
    );
endinterface

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin arbiter
// req: request pair, last: index served last, win: one-hot winner (zero when no request)
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] win
);
    // On contention the requester not served last wins; a lone request always wins.
    assign win = (req == 2'b11) ? (last ? 2'b01 : 2'b10) : req;
endmodule

// File: rtl/mult_sched.sv
// mult_sched: round-robin sequencer driving the shared shift-add multiplier datapath
// clk: clock, reset: async active-low, bus: client handshake and datapath controls
module mult_sched
    import mult_sched_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic         clk,
    input  logic         reset,
    mult_sched_if.master bus
);
    state_t          state;
    state_t          nxt;
    logic [CNT_W-1:0] cnt;
    logic            last;
    logic [NREQ-1:0] gnt_q;
    logic [NREQ-1:0] win;

    rr_arb2 u_arb (
        .req  (bus.req),
        .last (last),
        .win  (win)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = (bus.req != '0) ? LOAD : IDLE;
            LOAD:    nxt = EXEC;
            EXEC:    nxt = (cnt == '0) ? DONE : EXEC;
            DONE:    nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    // last resets to 1 so requester 0 wins the first contention.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt   <= '0;
            last  <= 1'b1;
            gnt_q <= '0;
        end else begin
            if (state == IDLE && bus.req != '0) gnt_q <= win;
            if (state == DONE) begin
                gnt_q <= '0;
                last  <= gnt_q[1];
            end
            if (state == LOAD)      cnt <= CNT_W'(WIDTH - 1);
            else if (state == EXEC) cnt <= cnt - CNT_W'(1);
        end
    end

    // sign/cout pass only in EXEC; the ternary keeps unknown inputs off the outputs elsewhere.
    always_comb begin
        bus.gnt   = gnt_q;
        bus.done  = (state == DONE) ? gnt_q : '0;
        bus.busy  = state != IDLE;
        bus.load  = state == LOAD;
        bus.sel   = (state == LOAD) ? SEL_LOAD :
                    (state == EXEC) ? SEL_EXEC :
                    (state == DONE) ? SEL_DONE : SEL_IDLE;
        bus.shift = state == EXEC;
        bus.add   = (state == EXEC) ? bus.sign : 1'b0;
        bus.inbit = (state == EXEC) ? (bus.sign & bus.cout) : 1'b0;
        bus.valid = state == DONE;
    end
endmodule
